// File: rtl/com_bridge.sv
// J1 peripheral bridge: stages {comando,datos} pairs, queues them in a small FIFO
// and dispatches them one at a time to the UART sender stage with a launch/ack handshake.
module com_bridge #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    output logic [7:0]  datos,
    output logic [7:0]  comando,
    output logic        start_j1,
    input  logic        bussy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [7:0]      datos_st_q, datos_st_d;
    logic [7:0]      comando_st_q, comando_st_d;
    logic            ovf_q, ovf_d;
    logic            tmo_q, tmo_d;
    logic [15:0]     d_out_q, d_out_d;
    logic [7:0]      datos_q, datos_d;
    logic [7:0]      comando_q, comando_d;
    logic            start_q, start_d;

    logic            wr_en_s, rd_en_s, push_req_s, push_s, clr_s;
    logic            full_s, empty_s, active_s;
    logic            pop_s, launch_s, tmo_set_s;
    logic [15:0]     head_s, rd_data_s;
    logic            unused_s;

    assign wr_en_s    = cs & wr;
    assign rd_en_s    = cs & rd;
    assign push_req_s = wr_en_s && (addr == 4'h4);
    assign clr_s      = wr_en_s && (addr == 4'h6) && d_in[0];
    assign full_s     = (count_q == CW'(FIFO_DEPTH));
    assign empty_s    = (count_q == CW'(0));
    assign push_s     = push_req_s & ~full_s;
    assign active_s   = (state_q != S_IDLE);
    assign head_s     = mem_q[rd_ptr_q];
    assign unused_s   = ^d_in[15:8];

    // Dispatch state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Dispatch next-state logic; the head stays queued until the sender acknowledges or times out
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pop_s     = 1'b0;
        launch_s  = 1'b0;
        tmo_set_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_s && !bussy) begin
                    state_d  = S_LAUNCH;
                    launch_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (bussy) begin
                    state_d = S_WAIT_LO;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    tmo_set_s = 1'b1;
                    pop_s     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!bussy) begin
                    pop_s   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Dispatch outputs: payload latched on launch and held until the next launch
    always_comb begin
        start_d   = (state_d == S_LAUNCH);
        datos_d   = datos_q;
        comando_d = comando_q;
        if (launch_s) begin
            comando_d = head_s[15:8];
            datos_d   = head_s[7:0];
        end else begin
            comando_d = comando_q;
            datos_d   = datos_q;
        end
    end

    // FIFO bookkeeping; a push into a full FIFO is dropped even when a pop frees a slot
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = (ovf_q & ~clr_s) | (push_req_s & full_s);
        tmo_d = (tmo_q & ~clr_s) | tmo_set_s;
    end

    // Register file writes and read mux
    always_comb begin
        datos_st_d   = (wr_en_s && (addr == 4'h0)) ? d_in[7:0] : datos_st_q;
        comando_st_d = (wr_en_s && (addr == 4'h2)) ? d_in[7:0] : comando_st_q;
        case (addr)
            4'h0:    rd_data_s = {8'h00, datos_st_q};
            4'h2:    rd_data_s = {8'h00, comando_st_q};
            4'h6:    rd_data_s = {6'd0, tmo_q, ovf_q, active_s, full_s, empty_s, 5'(count_q)};
            default: rd_data_s = 16'h0000;
        endcase
        d_out_d = rd_en_s ? rd_data_s : d_out_q;
    end

    // Datapath and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            datos_st_q   <= 8'h00;
            comando_st_q <= 8'h00;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
            d_out_q      <= 16'h0000;
            datos_q      <= 8'h00;
            comando_q    <= 8'h00;
            start_q      <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            datos_st_q   <= datos_st_d;
            comando_st_q <= comando_st_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            d_out_q      <= d_out_d;
            datos_q      <= datos_d;
            comando_q    <= comando_d;
            start_q      <= start_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {comando_st_q, datos_st_q};
        end
    end

    assign d_out    = d_out_q;
    assign datos    = datos_q;
    assign comando  = comando_q;
    assign start_j1 = start_q;

endmodule
